// File: rtl/frontier_pkg.sv
// Shared types and sizing helpers for the frontier collection stage.
// Default build-time sizes can be overridden by defining the macros before this file.
`ifndef V_ID_WIDTH
`define V_ID_WIDTH 32
`endif
`ifndef CORE_NUM
`define CORE_NUM 4
`endif
`ifndef ITERATION_WIDTH
`define ITERATION_WIDTH 8
`endif

package frontier_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_NEXT  = 2'd2,
    ST_DONE  = 2'd3
  } lane_state_t;

  // Pointer width for a power-of-two FIFO; count needs one extra bit to hold "full".
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/frontier_collect_lane.sv
// One lane: frontier FIFO with a registered output stage plus the iteration FSM.
module frontier_collect_lane
  import frontier_pkg::*;
#(
  parameter int V_ID_WIDTH      = 32,
  parameter int ITERATION_WIDTH = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int MAX_ITERATION   = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [V_ID_WIDTH-1:0]      front_active_v_id,
  input  logic                       front_active_v_updated,
  input  logic                       front_active_v_valid,
  input  logic                       front_iteration_end,
  input  logic                       front_iteration_end_valid,
  input  logic                       next_v_ready,
  output logic [V_ID_WIDTH-1:0]      next_v_id,
  output logic                       next_v_valid,
  output logic                       iteration_start,
  output logic [ITERATION_WIDTH-1:0] iteration_id,
  output logic                       converged,
  output logic                       limit_reached,
  output logic                       overflow
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ITERATION_WIDTH-1:0] LAST_ITER = ITERATION_WIDTH'(MAX_ITERATION);

  logic [V_ID_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      mem_count;
  lane_state_t           state;
  logic                  any_updated;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic                  load;
  logic                  iter_end;
  logic                  drained;

  // count covers the output register too, so total capacity is exactly FIFO_DEPTH
  always_comb begin
    push_req  = front_active_v_valid && front_active_v_updated &&
                (state == ST_RUN || state == ST_DRAIN);
    pop       = next_v_valid && next_v_ready;
    push_ok   = push_req && ((count < FULL_CNT) || pop);
    mem_count = count - CNT_W'(next_v_valid);
    load      = (mem_count != '0) && (!next_v_valid || pop);
    iter_end  = front_iteration_end_valid && front_iteration_end;
    drained   = (count == '0) && !push_req;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= front_active_v_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      next_v_id       <= '0;
      next_v_valid    <= 1'b0;
      iteration_start <= 1'b0;
      iteration_id    <= '0;
      converged       <= 1'b0;
      limit_reached   <= 1'b0;
      overflow        <= 1'b0;
      any_updated     <= 1'b0;
      state           <= ST_RUN;
    end else begin
      iteration_start <= 1'b0;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        next_v_id    <= mem[rd_ptr];
        next_v_valid <= 1'b1;
        rd_ptr       <= rd_ptr + 1'b1;
      end else if (pop) begin
        next_v_valid <= 1'b0;
      end
      if (push_req) begin
        any_updated <= 1'b1;
        if (!push_ok) begin
          overflow <= 1'b1;
        end
      end

      unique case (state)
        ST_RUN: begin
          if (iter_end) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drained) begin
            if (!any_updated) begin
              converged <= 1'b1;
              state     <= ST_DONE;
            end else if (iteration_id == LAST_ITER) begin
              limit_reached <= 1'b1;
              state         <= ST_DONE;
            end else begin
              iteration_start <= 1'b1;
              iteration_id    <= iteration_id + 1'b1;
              any_updated     <= 1'b0;
              state           <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          state <= ST_RUN;
        end
        ST_DONE: begin
          next_v_valid <= 1'b0;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: rtl/frontier_collect.sv
// Frontier collection top: one independent lane per core, buses sliced per lane.
module frontier_collect
  import frontier_pkg::*;
#(
  parameter int V_ID_WIDTH      = `V_ID_WIDTH,
  parameter int CORE_NUM        = `CORE_NUM,
  parameter int ITERATION_WIDTH = `ITERATION_WIDTH,
  parameter int FIFO_DEPTH      = 16,
  parameter int MAX_ITERATION   = 2**ITERATION_WIDTH - 1
) (
  input  logic                                clk,
  input  logic [CORE_NUM-1:0]                 rst,
  input  logic [CORE_NUM*V_ID_WIDTH-1:0]      front_active_v_id,
  input  logic [CORE_NUM-1:0]                 front_active_v_updated,
  input  logic [CORE_NUM-1:0]                 front_active_v_valid,
  input  logic [CORE_NUM-1:0]                 front_iteration_end,
  input  logic [CORE_NUM-1:0]                 front_iteration_end_valid,
  input  logic [CORE_NUM-1:0]                 next_v_ready,
  output logic [CORE_NUM*V_ID_WIDTH-1:0]      next_v_id,
  output logic [CORE_NUM-1:0]                 next_v_valid,
  output logic [CORE_NUM-1:0]                 iteration_start,
  output logic [CORE_NUM*ITERATION_WIDTH-1:0] iteration_id,
  output logic [CORE_NUM-1:0]                 converged,
  output logic [CORE_NUM-1:0]                 limit_reached,
  output logic [CORE_NUM-1:0]                 overflow
);

  for (genvar i = 0; i < CORE_NUM; i++) begin : g_lane
    frontier_collect_lane #(
      .V_ID_WIDTH      (V_ID_WIDTH),
      .ITERATION_WIDTH (ITERATION_WIDTH),
      .FIFO_DEPTH      (FIFO_DEPTH),
      .MAX_ITERATION   (MAX_ITERATION)
    ) u_lane (
      .clk                       (clk),
      .rst                       (rst[i]),
      .front_active_v_id         (front_active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH]),
      .front_active_v_updated    (front_active_v_updated[i]),
      .front_active_v_valid      (front_active_v_valid[i]),
      .front_iteration_end       (front_iteration_end[i]),
      .front_iteration_end_valid (front_iteration_end_valid[i]),
      .next_v_ready              (next_v_ready[i]),
      .next_v_id                 (next_v_id[i*V_ID_WIDTH +: V_ID_WIDTH]),
      .next_v_valid              (next_v_valid[i]),
      .iteration_start           (iteration_start[i]),
      .iteration_id              (iteration_id[i*ITERATION_WIDTH +: ITERATION_WIDTH]),
      .converged                 (converged[i]),
      .limit_reached             (limit_reached[i]),
      .overflow                  (overflow[i])
    );
  end

endmodule

// File: tb/tb_frontier_collect.sv
// Scenario bench for frontier_collect: per-lane scoreboards of expected frontier ids.
module tb_frontier_collect;

  localparam int VW    = 8;
  localparam int CN    = 2;
  localparam int IW    = 4;
  localparam int DEPTH = 16;
  localparam int MAXIT = 2;

  logic              clk = 1'b0;
  logic [CN-1:0]     rst;
  logic [CN*VW-1:0]  front_active_v_id;
  logic [CN-1:0]     front_active_v_updated;
  logic [CN-1:0]     front_active_v_valid;
  logic [CN-1:0]     front_iteration_end;
  logic [CN-1:0]     front_iteration_end_valid;
  logic [CN-1:0]     next_v_ready;
  logic [CN*VW-1:0]  next_v_id;
  logic [CN-1:0]     next_v_valid;
  logic [CN-1:0]     iteration_start;
  logic [CN*IW-1:0]  iteration_id;
  logic [CN-1:0]     converged;
  logic [CN-1:0]     limit_reached;
  logic [CN-1:0]     overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [VW-1:0] q0[$];
  logic [VW-1:0] q1[$];

  always #5 clk = ~clk;

  frontier_collect #(
    .V_ID_WIDTH      (VW),
    .CORE_NUM        (CN),
    .ITERATION_WIDTH (IW),
    .FIFO_DEPTH      (DEPTH),
    .MAX_ITERATION   (MAXIT)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .front_active_v_id         (front_active_v_id),
    .front_active_v_updated    (front_active_v_updated),
    .front_active_v_valid      (front_active_v_valid),
    .front_iteration_end       (front_iteration_end),
    .front_iteration_end_valid (front_iteration_end_valid),
    .next_v_ready              (next_v_ready),
    .next_v_id                 (next_v_id),
    .next_v_valid              (next_v_valid),
    .iteration_start           (iteration_start),
    .iteration_id              (iteration_id),
    .converged                 (converged),
    .limit_reached             (limit_reached),
    .overflow                  (overflow)
  );

  // Every handshake seen mid-cycle is a pop at the next edge; compare it with the lane's scoreboard.
  always @(negedge clk) begin
    logic [VW-1:0] got;
    logic [VW-1:0] exp_id;
    for (int l = 0; l < CN; l++) begin
      if (!rst[l] && next_v_valid[l] && next_v_ready[l]) begin
        got = next_v_id[l*VW +: VW];
        total_cnt++;
        if ((l == 0 && q0.size() == 0) || (l == 1 && q1.size() == 0)) begin
          $display("[TB] FAIL pop_order lane%0d: got id %0d, expected no output", l, got);
        end else begin
          if (l == 0) exp_id = q0.pop_front();
          else        exp_id = q1.pop_front();
          if (got !== exp_id)
            $display("[TB] FAIL pop_order lane%0d: got id %0d, expected %0d", l, got, exp_id);
          else
            pass_cnt++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d passed", pass_cnt, total_cnt);
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int lane, input logic [VW-1:0] id,
                               input logic upd, input logic vld);
    front_active_v_id[lane*VW +: VW] = id;
    front_active_v_updated[lane]     = upd;
    front_active_v_valid[lane]       = vld;
  endtask

  task automatic set_end(input int lane, input logic e, input logic vld);
    front_iteration_end[lane]       = e;
    front_iteration_end_valid[lane] = vld;
  endtask

  task automatic clear_inputs();
    front_active_v_id         = '0;
    front_active_v_updated    = '0;
    front_active_v_valid      = '0;
    front_iteration_end       = '0;
    front_iteration_end_valid = '0;
  endtask

  task automatic reset_all();
    rst = '1;
    clear_inputs();
    q0.delete();
    q1.delete();
    step();
    step();
    rst = '0;
    step();
  endtask

  task automatic test_reset();
    rst = '1;
    clear_inputs();
    next_v_ready = '1;
    step();
    step();
    total_cnt++;
    if ({next_v_valid, iteration_start, converged, limit_reached, overflow} !== '0)
      $display("[TB] FAIL reset_flags: got %b, expected 0",
               {next_v_valid, iteration_start, converged, limit_reached, overflow});
    else pass_cnt++;
    total_cnt++;
    if (next_v_id !== '0) $display("[TB] FAIL reset_id: got %h, expected 0", next_v_id);
    else pass_cnt++;
    total_cnt++;
    if (iteration_id !== '0) $display("[TB] FAIL reset_iter: got %h, expected 0", iteration_id);
    else pass_cnt++;
    rst = '0;
    step();
  endtask

  task automatic test_basic();
    reset_all();
    next_v_ready = '1;
    applyStimulus(0, 8'd5, 1'b1, 1'b1);
    q0.push_back(8'd5);
    step();
    total_cnt++;
    if (next_v_valid[0] !== 1'b0) $display("[TB] FAIL latency_early: got valid %b, expected 0", next_v_valid[0]);
    else pass_cnt++;
    applyStimulus(0, 8'd7, 1'b0, 1'b1);
    step();
    total_cnt++;
    if (next_v_valid[0] !== 1'b1 || next_v_id[VW-1:0] !== 8'd5)
      $display("[TB] FAIL first_out: got valid %b id %0d, expected valid 1 id 5", next_v_valid[0], next_v_id[VW-1:0]);
    else pass_cnt++;
    applyStimulus(0, 8'd9, 1'b1, 1'b1);
    q0.push_back(8'd9);
    step();
    clear_inputs();
    repeat (5) step();
    total_cnt++;
    if (q0.size() !== 0) $display("[TB] FAIL basic_drain: got %0d ids pending, expected 0", q0.size());
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    reset_all();
    next_v_ready = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i == DEPTH) begin
        total_cnt++;
        if (overflow[0] !== 1'b0) $display("[TB] FAIL overflow_at_full: got %b, expected 0", overflow[0]);
        else pass_cnt++;
      end
      applyStimulus(0, VW'(10 + i), 1'b1, 1'b1);
      if (i < DEPTH) q0.push_back(VW'(10 + i));
      step();
    end
    clear_inputs();
    step();
    total_cnt++;
    if (overflow[0] !== 1'b1) $display("[TB] FAIL overflow_set: got %b, expected 1", overflow[0]);
    else pass_cnt++;
    total_cnt++;
    if (next_v_valid[0] !== 1'b1 || next_v_id[VW-1:0] !== 8'd10)
      $display("[TB] FAIL hold_stable: got valid %b id %0d, expected valid 1 id 10", next_v_valid[0], next_v_id[VW-1:0]);
    else pass_cnt++;
    next_v_ready[0] = 1'b1;
    applyStimulus(0, 8'd99, 1'b1, 1'b1);
    q0.push_back(8'd99);
    step();
    clear_inputs();
    repeat (25) step();
    total_cnt++;
    if (q0.size() !== 0) $display("[TB] FAIL overflow_drain: got %0d ids pending, expected 0", q0.size());
    else pass_cnt++;
    total_cnt++;
    if (next_v_valid[0] !== 1'b0) $display("[TB] FAIL overflow_empty: got valid %b, expected 0", next_v_valid[0]);
    else pass_cnt++;
  endtask

  task automatic test_iteration();
    bit seen;
    reset_all();
    next_v_ready = '0;
    applyStimulus(0, 8'd30, 1'b1, 1'b1); q0.push_back(8'd30); step();
    applyStimulus(0, 8'd31, 1'b1, 1'b1); q0.push_back(8'd31); step();
    applyStimulus(0, 8'd32, 1'b1, 1'b1); q0.push_back(8'd32);
    set_end(0, 1'b1, 1'b1);
    step();
    clear_inputs();
    step();
    total_cnt++;
    if (iteration_start[0] !== 1'b0 || iteration_id[IW-1:0] !== 4'd0)
      $display("[TB] FAIL drain_wait: got start %b iter %0d, expected 0 0", iteration_start[0], iteration_id[IW-1:0]);
    else pass_cnt++;
    next_v_ready[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step();
      if (iteration_start[0]) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b1) $display("[TB] FAIL iter_start_timeout: got no pulse, expected pulse within 40 cycles");
    else pass_cnt++;
    total_cnt++;
    if (q0.size() !== 0) $display("[TB] FAIL iter_drained: got %0d ids pending, expected 0", q0.size());
    else pass_cnt++;
    total_cnt++;
    if (iteration_id[IW-1:0] !== 4'd1) $display("[TB] FAIL iter_incr: got %0d, expected 1", iteration_id[IW-1:0]);
    else pass_cnt++;
    step();
    total_cnt++;
    if (iteration_start[0] !== 1'b0) $display("[TB] FAIL iter_pulse_width: got %b, expected 0", iteration_start[0]);
    else pass_cnt++;
  endtask

  task automatic test_converged();
    bit pulsed;
    bit done;
    applyStimulus(0, 8'd44, 1'b0, 1'b1);
    set_end(0, 1'b0, 1'b1);
    step();
    clear_inputs();
    repeat (3) step();
    total_cnt++;
    if (converged[0] !== 1'b0) $display("[TB] FAIL end_zero_ignored: got converged %b, expected 0", converged[0]);
    else pass_cnt++;
    set_end(0, 1'b1, 1'b1);
    step();
    clear_inputs();
    pulsed = 1'b0;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (iteration_start[0]) pulsed = 1'b1;
      if (converged[0]) done = 1'b1;
    end
    total_cnt++;
    if (done !== 1'b1) $display("[TB] FAIL converge_timeout: got converged 0, expected 1 within 20 cycles");
    else pass_cnt++;
    total_cnt++;
    if (pulsed !== 1'b0 || iteration_id[IW-1:0] !== 4'd1 || limit_reached[0] !== 1'b0)
      $display("[TB] FAIL converge_state: got start %b iter %0d limit %b, expected 0 1 0",
               pulsed, iteration_id[IW-1:0], limit_reached[0]);
    else pass_cnt++;
    applyStimulus(0, 8'd45, 1'b1, 1'b1);
    step();
    clear_inputs();
    repeat (3) step();
    total_cnt++;
    if (next_v_valid[0] !== 1'b0) $display("[TB] FAIL done_ignores: got valid %b, expected 0", next_v_valid[0]);
    else pass_cnt++;
  endtask

  task automatic test_limit();
    bit ok;
    reset_all();
    next_v_ready = '1;
    for (int it = 0; it <= MAXIT; it++) begin
      applyStimulus(0, VW'(40 + it), 1'b1, 1'b1);
      q0.push_back(VW'(40 + it));
      step();
      clear_inputs();
      set_end(0, 1'b1, 1'b1);
      step();
      clear_inputs();
      ok = 1'b0;
      for (int c = 0; c < 30 && !ok; c++) begin
        step();
        if (it < MAXIT ? iteration_start[0] : limit_reached[0]) ok = 1'b1;
      end
      total_cnt++;
      if (ok !== 1'b1) $display("[TB] FAIL limit_progress it%0d: got no event, expected one within 30 cycles", it);
      else pass_cnt++;
      total_cnt++;
      if (iteration_id[IW-1:0] !== IW'(it < MAXIT ? it + 1 : MAXIT))
        $display("[TB] FAIL limit_iter it%0d: got %0d, expected %0d", it, iteration_id[IW-1:0],
                 (it < MAXIT ? it + 1 : MAXIT));
      else pass_cnt++;
      if (it < MAXIT) step();
    end
    total_cnt++;
    if (converged[0] !== 1'b0) $display("[TB] FAIL limit_not_converged: got %b, expected 0", converged[0]);
    else pass_cnt++;
    applyStimulus(0, 8'd55, 1'b1, 1'b1);
    step();
    clear_inputs();
    repeat (3) step();
    total_cnt++;
    if (next_v_valid[0] !== 1'b0 || q0.size() !== 0)
      $display("[TB] FAIL limit_done: got valid %b pending %0d, expected 0 0", next_v_valid[0], q0.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back_reset();
    reset_all();
    next_v_ready = 2'b10;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1, VW'(60 + c), 1'b1, 1'b1);
      q1.push_back(VW'(60 + c));
      if (c < 3) begin
        applyStimulus(0, VW'(20 + c), 1'b1, 1'b1);
        q0.push_back(VW'(20 + c));
      end else begin
        applyStimulus(0, 8'd0, 1'b0, 1'b0);
      end
      if (c == 2) set_end(0, 1'b1, 1'b1);
      else        set_end(0, 1'b0, 1'b0);
      step();
    end
    clear_inputs();
    step();
    total_cnt++;
    if (next_v_valid[0] !== 1'b1 || next_v_id[VW-1:0] !== 8'd20)
      $display("[TB] FAIL pre_reset_hold: got valid %b id %0d, expected 1 20", next_v_valid[0], next_v_id[VW-1:0]);
    else pass_cnt++;
    rst[0] = 1'b1;
    q0.delete();
    #1;
    total_cnt++;
    if (next_v_valid[0] !== 1'b0 || next_v_id[VW-1:0] !== 8'd0)
      $display("[TB] FAIL async_reset: got valid %b id %0d, expected 0 0", next_v_valid[0], next_v_id[VW-1:0]);
    else pass_cnt++;
    applyStimulus(1, 8'd70, 1'b1, 1'b1);
    q1.push_back(8'd70);
    step();
    clear_inputs();
    step();
    rst[0] = 1'b0;
    next_v_ready = '1;
    repeat (6) step();
    total_cnt++;
    if (q1.size() !== 0) $display("[TB] FAIL lane1_unaffected: got %0d ids pending, expected 0", q1.size());
    else pass_cnt++;
    total_cnt++;
    if (next_v_valid[0] !== 1'b0 || iteration_id[IW-1:0] !== 4'd0)
      $display("[TB] FAIL lane0_discarded: got valid %b iter %0d, expected 0 0", next_v_valid[0], iteration_id[IW-1:0]);
    else pass_cnt++;
  endtask

  initial begin
    rst          = '1;
    next_v_ready = '0;
    clear_inputs();
    test_reset();
    test_basic();
    test_overflow();
    test_iteration();
    test_converged();
    test_limit();
    test_back_to_back_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/frontier_collect.md
Name: frontier_collect

Overview:
- Sits directly downstream of the apply iteration-end stage, one lane per core.
- Captures each lane's applied vertices that have `updated=1` into a per-lane FIFO. This FIFO is the next-iteration frontier.
- Drains the FIFO to the vertex-dispatch front end with a valid/ready handshake.
- A per-lane FSM sequences iterations: on iteration end it drains, then either starts the next iteration or declares convergence / iteration-limit completion.

Parameters:
- `V_ID_WIDTH`, `` `V_ID_WIDTH ``, vertex id width
- `CORE_NUM`, `` `CORE_NUM ``, number of lanes
- `ITERATION_WIDTH`, `` `ITERATION_WIDTH ``, iteration counter width
- `FIFO_DEPTH`, 16, per-lane frontier FIFO entries (power of two, ≥2)
- `MAX_ITERATION`, `2**ITERATION_WIDTH-1`, last iteration index allowed

Ports:
- `clk`  in  1  single clock
- `rst`  in  `CORE_NUM`  per-lane reset, asynchronous, active-high
- `front_active_v_id`  in  `CORE_NUM*V_ID_WIDTH`  applied vertex id per lane
- `front_active_v_updated`  in  `CORE_NUM`  vertex value changed this iteration
- `front_active_v_valid`  in  `CORE_NUM`  id/updated valid
- `front_iteration_end`  in  `CORE_NUM`  combined iteration-end flag
- `front_iteration_end_valid`  in  `CORE_NUM`  qualifies `front_iteration_end`
- `next_v_ready`  in  `CORE_NUM`  downstream accepts `next_v_id`
- `next_v_id`  out  `CORE_NUM*V_ID_WIDTH`  frontier vertex id
- `next_v_valid`  out  `CORE_NUM`  `next_v_id` valid
- `iteration_start`  out  `CORE_NUM`  1-cycle pulse: next iteration begins
- `iteration_id`  out  `CORE_NUM*ITERATION_WIDTH`  current iteration index
- `converged`  out  `CORE_NUM`  sticky: finished with no updates
- `limit_reached`  out  `CORE_NUM`  sticky: finished at `MAX_ITERATION`
- `overflow`  out  `CORE_NUM`  sticky: a vertex was dropped on a full FIFO

Behaviour:
- All registers reset asynchronously on `rst[i]` high; lane i is independent of the other lanes.
- Reset values:
  - `next_v_id=0`, `next_v_valid=0`, `iteration_start=0`, `iteration_id=0`
  - `converged=0`, `limit_reached=0`, `overflow=0`
  - FIFO empty, `any_updated=0`, state RUN
- Reset asserted mid-operation discards FIFO contents immediately.
- Push:
  - Condition: `front_active_v_valid & front_active_v_updated`, in state RUN or DRAIN.
  - Entries with `updated=0` are ignored.
  - A push sets `any_updated`.
  - Push is accepted if count<`FIFO_DEPTH`, or if count==`FIFO_DEPTH` and a pop occurs in the same cycle.
  - Otherwise the entry is dropped and `overflow` is set (sticky until reset). No backpressure exists upstream.
- Pop:
  - A pop occurs when `next_v_valid & next_v_ready`.
  - Output is registered. An id pushed into an empty FIFO appears on `next_v_id` with `next_v_valid=1` exactly 1 cycle after the capturing edge.
  - `next_v_id` holds stable while `valid & !ready`.
  - Order is strictly FIFO.
  - Read/write pointers are log2(`FIFO_DEPTH`) bits and wrap. Count is log2(`FIFO_DEPTH`)+1 bits.
- FSM states: RUN, DRAIN, NEXT, DONE.
- RUN → DRAIN:
  - Trigger: `front_iteration_end_valid & front_iteration_end`.
  - A vertex arriving in the same cycle belongs to the ending iteration and is pushed.
- DRAIN:
  - Pushes continue, to absorb pipeline stragglers.
  - When the FIFO is empty and no push occurs that cycle:
    - `any_updated=0` → DONE, `converged=1`.
    - `iteration_id==MAX_ITERATION` → DONE, `limit_reached=1`.
    - Otherwise → NEXT.
  - If both conditions hold, `converged` takes priority.
- NEXT:
  - Stays one cycle.
  - `iteration_start=1`, `iteration_id+=1`, `any_updated` cleared, then → RUN.
- DONE:
  - Terminal until reset.
  - Inputs are ignored and `next_v_valid=0`.
- `front_iteration_end_valid` with `front_iteration_end=0` has no effect.
- An iteration-end seen in DRAIN or NEXT is ignored.

Decomposition:
- Shared package `frontier_pkg`:
  - FSM state encoding (RUN=0, DRAIN=1, NEXT=2, DONE=3)
  - FIFO pointer/count width derived via `$clog2(FIFO_DEPTH)`
- Sub-module `frontier_collect_lane`: one lane (FIFO, FSM, counters).
- The top is a generate loop over `CORE_NUM` lanes with bus slicing.

Test Plan:
- Reset then push ids 5,9 with `updated=1` and `ready=1` → `next_v_id` 5 then 9, first one 1 cycle after capture; `updated=0` id 7 never appears.
- Hold `ready=0`, push `FIFO_DEPTH`+1 ids → first 16 retained in order, 17th dropped, `overflow=1`; push+pop on the same full cycle → no drop.
- Iteration end with 3 queued ids, `ready=1` → drained, then `iteration_start` pulse, `iteration_id` 0→1.
- Iteration with zero updated pushes then iteration end → `converged=1`, `iteration_start` never pulses, `iteration_id` unchanged.
- `MAX_ITERATION=2`, every iteration updates → after the iteration 2 end: `limit_reached=1`, DONE, later pushes ignored.
- Assert `rst[0]` mid-DRAIN with data queued, lane 1 active → lane 0 outputs zero immediately, lane 1 unaffected.
